// File: rtl/huffman_merge_ctrl.sv
// ---------------------------------------------------------------------------
// huffman_merge_ctrl
// Sequences Huffman tree construction around an external 10-node sorter.
// Loads 10 leaves, then runs 9 rounds. Each round hands the node set to the
// sorter, waits for the sorted result, merges the two lightest nodes into a
// parent and writes one tree-table entry. Node format: {weight[7:0], id[4:0]}.
//
// Ports
//   CLK          clock, rising edge
//   RST          synchronous reset, active-high
//   start        begin a build (sampled only when idle)
//   leaf_in      10 leaves, node k at [13k+12:13k]
//   node_bus     current node set presented to the sorter
//   sort_begin   one-cycle sorter request
//   sort_over    sorter result valid (level, sticky in the sorter)
//   sort_result  sorted nodes, ascending, lightest at [12:0]
//   tree_we      tree-table write strobe
//   tree_addr    round index 0..8
//   tree_data    {parent_id, left_id, right_id}
//   root         final root node, valid from the done pulse
//   busy         high while a build is in progress
//   done         one-cycle completion pulse (normal end or timeout)
//   err          sticky sort-timeout flag
// ---------------------------------------------------------------------------
module huffman_merge_ctrl #(
   parameter int unsigned SETTLE    = 4,
   parameter int unsigned TIMEOUT   = 255,
   parameter int unsigned FIRST_PID = 10
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          start,
   input  logic [129:0]  leaf_in,
   output logic [129:0]  node_bus,
   output logic          sort_begin,
   input  logic          sort_over,
   input  logic [129:0]  sort_result,
   output logic          tree_we,
   output logic [3:0]    tree_addr,
   output logic [14:0]   tree_data,
   output logic [12:0]   root,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam int unsigned NODE_W     = 13;
   localparam int unsigned ROUND_W    = 4;
   localparam int unsigned WAIT_W     = 9;
   localparam int unsigned LAST_ROUND = 8;

   localparam logic [NODE_W-1:0] SENTINEL = {8'hFF, 5'h1F};
   localparam logic [7:0]        W_SAT    = 8'hFE;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SORT_REQ,
      S_SORT_WAIT,
      S_MERGE,
      S_FINISH
   } state_t;

   state_t              r_state;
   logic [ROUND_W-1:0]  r_round;
   logic [WAIT_W-1:0]   r_wait;

   logic [7:0]          w_s0_w;
   logic [7:0]          w_s1_w;
   logic [4:0]          w_s0_id;
   logic [4:0]          w_s1_id;
   logic [8:0]          w_sum;
   logic [7:0]          w_par_w;
   logic [4:0]          w_par_id;
   logic [NODE_W-1:0]   w_parent;
   logic [129:0]        w_next_bus;
   logic                w_settled;
   logic                w_expired;
   logic                w_last;

   // Two lightest nodes straight off the sorter result.
   assign w_s0_w  = sort_result[12:5];
   assign w_s0_id = sort_result[4:0];
   assign w_s1_w  = sort_result[25:18];
   assign w_s1_id = sort_result[17:13];

   // Parent weight saturates below the sentinel so sentinels always sort last.
   assign w_sum    = {1'b0, w_s0_w} + {1'b0, w_s1_w};
   assign w_par_w  = (w_sum > {1'b0, W_SAT}) ? W_SAT : w_sum[7:0];
   assign w_par_id = 5'(FIRST_PID) + 5'(r_round);
   assign w_parent = {w_par_w, w_par_id};

   // Consumed slots 0/1 are replaced by the parent (slot 0) and a sentinel (slot 9).
   assign w_next_bus = {SENTINEL, sort_result[129:26], w_parent};

   // Wait counter counts SORT_WAIT cycles from 0; sort_over is ignored until SETTLE.
   assign w_settled = (r_wait >= WAIT_W'(SETTLE));
   assign w_expired = (r_wait == WAIT_W'(SETTLE + TIMEOUT - 1));
   assign w_last    = (r_round == ROUND_W'(LAST_ROUND));

   // Controller FSM; all outputs registered. Write-side outputs are set on entry
   // to MERGE so tree_we is high during the MERGE cycle itself.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= S_IDLE;
         r_round    <= '0;
         r_wait     <= '0;
         node_bus   <= '0;
         sort_begin <= 1'b0;
         tree_we    <= 1'b0;
         tree_addr  <= '0;
         tree_data  <= '0;
         root       <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         sort_begin <= 1'b0;
         tree_we    <= 1'b0;
         done       <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  node_bus <= leaf_in;
                  err      <= 1'b0;
                  root     <= '0;
                  r_round  <= '0;
                  busy     <= 1'b1;
                  r_state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               sort_begin <= 1'b1;
               r_state    <= S_SORT_REQ;
            end
            S_SORT_REQ: begin
               r_wait  <= '0;
               r_state <= S_SORT_WAIT;
            end
            S_SORT_WAIT: begin
               if (w_settled && sort_over) begin
                  tree_we   <= 1'b1;
                  tree_addr <= r_round;
                  tree_data <= {w_par_id, w_s0_id, w_s1_id};
                  node_bus  <= w_next_bus;
                  if (w_last) begin
                     root <= w_parent;
                  end
                  r_state <= S_MERGE;
               end else if (w_expired) begin
                  err     <= 1'b1;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_wait <= r_wait + WAIT_W'(1);
               end
            end
            S_MERGE: begin
               if (w_last) begin
                  done    <= 1'b1;
                  r_state <= S_FINISH;
               end else begin
                  r_round    <= r_round + ROUND_W'(1);
                  sort_begin <= 1'b1;
                  r_state    <= S_SORT_REQ;
               end
            end
            S_FINISH: begin
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_huffman_merge_ctrl.sv
// ---------------------------------------------------------------------------
// tb_huffman_merge_ctrl
// Directed bench for huffman_merge_ctrl with a behavioural sorter that orders
// nodes by {weight, id} ascending (ties on weight resolved by lower id first).
// ---------------------------------------------------------------------------
module tb_huffman_merge_ctrl;

   localparam int LAT      = 3;
   localparam int RND_LAT  = 6;     // sort_begin cycle to tree_we cycle
   localparam int TO_LAT   = 260;   // sort_begin cycle to timeout done cycle

   logic          CLK = 1'b0;
   logic          RST;
   logic          start;
   logic [129:0]  leaf_in;
   logic [129:0]  node_bus;
   logic          sort_begin;
   logic          sort_over = 1'b0;
   logic [129:0]  sort_result = '0;
   logic          tree_we;
   logic [3:0]    tree_addr;
   logic [14:0]   tree_data;
   logic [12:0]   root;
   logic          busy;
   logic          done;
   logic          err;

   huffman_merge_ctrl dut (
      .CLK         (CLK),
      .RST         (RST),
      .start       (start),
      .leaf_in     (leaf_in),
      .node_bus    (node_bus),
      .sort_begin  (sort_begin),
      .sort_over   (sort_over),
      .sort_result (sort_result),
      .tree_we     (tree_we),
      .tree_addr   (tree_addr),
      .tree_data   (tree_data),
      .root        (root),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   always #5 CLK = ~CLK;

   // Hand-derived tree for weights 1..10 (ids 0..9).
   localparam logic [14:0] EXP1 [9] = '{
      {5'd10, 5'd0,  5'd1 }, {5'd11, 5'd2,  5'd10}, {5'd12, 5'd3,  5'd4 },
      {5'd13, 5'd5,  5'd11}, {5'd14, 5'd6,  5'd7 }, {5'd15, 5'd8,  5'd12},
      {5'd16, 5'd9,  5'd13}, {5'd17, 5'd14, 5'd15}, {5'd18, 5'd16, 5'd17}
   };
   // Hand-derived tree for all weights 8'hF0.
   localparam logic [14:0] EXP2 [9] = '{
      {5'd10, 5'd0,  5'd1 }, {5'd11, 5'd2,  5'd3 }, {5'd12, 5'd4,  5'd5 },
      {5'd13, 5'd6,  5'd7 }, {5'd14, 5'd8,  5'd9 }, {5'd15, 5'd10, 5'd11},
      {5'd16, 5'd12, 5'd13}, {5'd17, 5'd14, 5'd15}, {5'd18, 5'd16, 5'd17}
   };
   localparam logic [12:0] ROOT1 = {8'd55,  5'd18};
   localparam logic [12:0] ROOT2 = {8'hFE,  5'd18};

   int n_vec = 0;
   int n_err = 0;

   // Monitor state
   int          cyc      = 0;
   int          wr_cnt   = 0;
   int          sb_cnt   = 0;
   int          sb_wide  = 0;
   int          done_cnt = 0;
   int          done_cyc = 0;
   bit          sb_prev  = 1'b0;
   logic [3:0]  wr_addr [128];
   logic [14:0] wr_data [128];
   logic [7:0]  wr_pw   [128];
   int          wr_cyc  [128];
   int          sb_cyc  [128];

   // Sorter model state
   int sorter_mode = 0;   // 0: latency LAT, 1: sort_over held high
   int hang_at     = -1;  // absolute sort_begin index that never completes
   int sb_seen     = 0;
   int s_cnt       = 0;

   function automatic logic [129:0] sort13(input logic [129:0] nb);
      logic [12:0]  a [10];
      logic [12:0]  t;
      logic [129:0] r;
      for (int k = 0; k < 10; k++) a[k] = nb[13*k +: 13];
      for (int i = 0; i < 9; i++)
         for (int j = 0; j < 9 - i; j++)
            if (a[j] > a[j+1]) begin
               t = a[j]; a[j] = a[j+1]; a[j+1] = t;
            end
      for (int k = 0; k < 10; k++) r[13*k +: 13] = a[k];
      return r;
   endfunction

   // Behavioural sorter, driven away from the active edge.
   always @(negedge CLK) begin
      sort_result = sort13(node_bus);
      if (sort_begin) begin
         sort_over = (sorter_mode == 1);
         s_cnt     = (sb_seen == hang_at) ? 0 : LAT;
         sb_seen++;
      end else if (sorter_mode == 1) begin
         sort_over = 1'b1;
      end else if (s_cnt > 0) begin
         s_cnt--;
         if (s_cnt == 0) sort_over = 1'b1;
      end
   end

   // Output monitor.
   always @(negedge CLK) begin
      cyc++;
      if (tree_we) begin
         if (wr_cnt < 128) begin
            wr_addr[wr_cnt] = tree_addr;
            wr_data[wr_cnt] = tree_data;
            wr_pw[wr_cnt]   = node_bus[12:5];
            wr_cyc[wr_cnt]  = cyc;
         end
         wr_cnt++;
      end
      if (sort_begin) begin
         if (sb_prev) sb_wide++;
         if (sb_cnt < 128) sb_cyc[sb_cnt] = cyc;
         sb_cnt++;
      end
      sb_prev = sort_begin;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [129:0] got, input logic [129:0] expv);
      n_vec++;
      if (got !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, expv);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int  d0;
      bit  ok;
      d0 = done_cnt;
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge CLK);
         #1;
         if (done_cnt != d0) begin
            ok = 1'b1;
            break;
         end
      end
      chk({tag, "_done_seen"}, 130'(ok), 130'(1));
   endtask

   task automatic check_tree(input string tag, input int base, input logic [14:0] ref_tab [9]);
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("%s_addr%0d", tag, i), 130'(wr_addr[base+i]), 130'(i));
         chk($sformatf("%s_data%0d", tag, i), 130'(wr_data[base+i]), 130'(ref_tab[i]));
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_node_bus"}, node_bus, '0);
      chk({tag, "_root"}, 130'(root), '0);
      chk({tag, "_tree"}, 130'({tree_addr, tree_data}), '0);
      chk({tag, "_strobes"}, 130'({sort_begin, tree_we, busy, done, err}), '0);
   endtask

   task automatic build_normal(input string tag, input logic [129:0] leaves,
                               input logic [14:0] ref_tab [9], input logic [12:0] ref_root);
      int wr0;
      int d0;
      wr0     = wr_cnt;
      d0      = done_cnt;
      leaf_in = leaves;
      do_start();
      chk({tag, "_busy_rise"}, 130'(busy), 130'(1));
      wait_done(tag);
      chk({tag, "_root"}, 130'(root), 130'(ref_root));
      tick();
      chk({tag, "_idle"}, 130'({busy, done}), '0);
      repeat (3) tick();
      chk({tag, "_wr_count"}, 130'(wr_cnt - wr0), 130'(9));
      chk({tag, "_done_count"}, 130'(done_cnt - d0), 130'(1));
      check_tree(tag, wr0, ref_tab);
   endtask

   logic [129:0] leaves1;
   logic [129:0] leaves2;
   logic [129:0] leaves_alt;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int wr0;
      int sb0;
      int sbw0;
      bit hit;

      for (int k = 0; k < 10; k++) begin
         leaves1[13*k +: 13]    = {8'(k + 1), 5'(k)};
         leaves2[13*k +: 13]    = {8'hF0, 5'(k)};
         leaves_alt[13*k +: 13] = {8'h11, 5'(k)};
      end

      RST     = 1'b1;
      start   = 1'b0;
      leaf_in = leaves1;
      repeat (3) tick();
      check_zero("reset");
      RST = 1'b0;
      tick();

      // 1. Basic build
      wr0 = wr_cnt;
      sb0 = sb_cnt;
      build_normal("basic", leaves1, EXP1, ROOT1);
      chk("basic_pw0", 130'(wr_pw[wr0]), 130'(3));
      chk("basic_pw1", 130'(wr_pw[wr0+1]), 130'(6));
      chk("basic_round_lat", 130'(wr_cyc[wr0] - sb_cyc[sb0]), 130'(RND_LAT));

      // 2. Saturation
      wr0 = wr_cnt;
      build_normal("sat", leaves2, EXP2, ROOT2);
      for (int i = 0; i < 9; i++)
         chk($sformatf("sat_pw%0d", i), 130'(wr_pw[wr0+i]), 130'(8'hFE));

      // 3. Sticky sort_over
      sorter_mode = 1;
      wr0  = wr_cnt;
      sb0  = sb_cnt;
      sbw0 = sb_wide;
      build_normal("sticky", leaves1, EXP1, ROOT1);
      chk("sticky_sb_count", 130'(sb_cnt - sb0), 130'(9));
      chk("sticky_sb_width", 130'(sb_wide - sbw0), '0);
      for (int i = 0; i < 9; i++)
         chk($sformatf("sticky_lat%0d", i), 130'(wr_cyc[wr0+i] - sb_cyc[sb0+i]), 130'(RND_LAT));
      sorter_mode = 0;

      // 4. Timeout in round 2
      wr0     = wr_cnt;
      sb0     = sb_cnt;
      hang_at = sb_seen + 2;
      leaf_in = leaves1;
      do_start();
      wait_done("tmo");
      chk("tmo_flags", 130'({err, busy}), 130'(2'b10));
      chk("tmo_latency", 130'(done_cyc - sb_cyc[sb0+2]), 130'(TO_LAT));
      chk("tmo_wr_count", 130'(wr_cnt - wr0), 130'(2));
      chk("tmo_wr_addr", 130'({wr_addr[wr0], wr_addr[wr0+1]}), 130'({4'd0, 4'd1}));
      tick();
      chk("tmo_err_sticky", 130'({err, done}), 130'(2'b10));
      hang_at = -1;
      do_start();
      chk("tmo_err_clear", 130'(err), '0);
      wait_done("tmo_rebuild");
      chk("tmo_rebuild_root", 130'(root), 130'(ROOT1));
      repeat (3) tick();

      // 5. Reset during round-4 SORT_WAIT, with start in the reset cycle
      wr0     = wr_cnt;
      sb0     = sb_cnt;
      leaf_in = leaves1;
      do_start();
      hit = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (sb_cnt - sb0 >= 5) begin
            hit = 1'b1;
            break;
         end
      end
      chk("rst_reach_round4", 130'(hit), 130'(1));
      tick();
      RST   = 1'b1;
      start = 1'b1;
      tick();
      check_zero("rst_mid");
      RST   = 1'b0;
      start = 1'b0;
      repeat (30) tick();
      chk("rst_wr_count", 130'(wr_cnt - wr0), 130'(4));
      chk("rst_quiet", 130'({sb_cnt - sb0, 1'b0, busy}), 130'({32'd5, 1'b0, 1'b0}));
      build_normal("rst_fresh", leaves1, EXP1, ROOT1);

      // 6. start ignored while busy
      wr0     = wr_cnt;
      sb0     = sb_cnt;
      leaf_in = leaves1;
      do_start();
      hit = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (sb_cnt - sb0 >= 2) begin
            hit = 1'b1;
            break;
         end
      end
      chk("busy_reach_round1", 130'(hit), 130'(1));
      leaf_in = leaves_alt;
      do_start();
      wait_done("busy");
      chk("busy_root", 130'(root), 130'(ROOT1));
      repeat (3) tick();
      chk("busy_wr_count", 130'(wr_cnt - wr0), 130'(9));
      check_tree("busy", wr0, EXP1);

      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
